// File: rtl/multicycle_control_pkg.sv
// Shared opcodes, FSM states, ALU function codes and instruction field positions
// for the multicycle sequencer.
package multicycle_control_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0,
        OP_SUB  = 4'h1,
        OP_AND  = 4'h2,
        OP_OR   = 4'h3,
        OP_XOR  = 4'h4,
        OP_SLT  = 4'h5,
        OP_ADDI = 4'h6,
        OP_LW   = 4'h7,
        OP_SW   = 4'h8,
        OP_BEQ  = 4'h9,
        OP_JMP  = 4'hA,
        OP_LUI  = 4'hB,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_AND,
        ALU_OR,
        ALU_XOR,
        ALU_SLT,
        ALU_PASS_B
    } alu_fn_t;

    localparam int unsigned OP_HI  = 15;
    localparam int unsigned OP_LO  = 12;
    localparam int unsigned RD_HI  = 11;
    localparam int unsigned RD_LO  = 9;
    localparam int unsigned RS1_HI = 8;
    localparam int unsigned RS1_LO = 6;
    localparam int unsigned RS2_HI = 5;
    localparam int unsigned RS2_LO = 3;
    localparam int unsigned IMM_HI = 5;
    localparam int unsigned IMM_LO = 0;

    function automatic logic [15:0] sext6(input logic [5:0] imm);
        return {{10{imm[5]}}, imm};
    endfunction

    // Address-forming ops (ADDI/LW/SW) and illegal opcodes fall through to ADD.
    function automatic alu_fn_t alu_fn_for(input opcode_t op);
        case (op)
            OP_SUB:  return ALU_SUB;
            OP_AND:  return ALU_AND;
            OP_OR:   return ALU_OR;
            OP_XOR:  return ALU_XOR;
            OP_SLT:  return ALU_SLT;
            OP_LUI:  return ALU_PASS_B;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_alu16.sv
// Combinational 16-bit ALU; all arithmetic wraps modulo 2^16, no flags.
module alu16
    import multicycle_control_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [2:0]  fn,
    output logic [15:0] result
);

    always_comb begin
        result = '0;
        case (alu_fn_t'(fn))
            ALU_ADD:    result = a + b;
            ALU_SUB:    result = a - b;
            ALU_AND:    result = a & b;
            ALU_OR:     result = a | b;
            ALU_XOR:    result = a ^ b;
            ALU_SLT:    result = {15'b0, ($signed(a) < $signed(b))};
            ALU_PASS_B: result = b;
            default:    result = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit Von Neumann CPU:
// owns PC, IR, A, B, ALUOut, MDR, the unified memory port and the regfile strobes.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [15:0] memAddr,
    output logic [15:0] memWriteData,
    output logic        memRead,
    output logic        memWrite,
    input  logic        memReady,
    input  logic [15:0] memReadData,
    output logic [2:0]  regSource1,
    output logic [2:0]  regSource2,
    output logic [2:0]  regDestination,
    output logic [15:0] writeData,
    output logic        writeEnable,
    input  logic [15:0] data1,
    input  logic [15:0] data2,
    output logic        halted,
    output logic [15:0] pc
);

    state_t      state;
    logic [15:0] pc_q;
    logic [15:0] ir;
    logic [15:0] a_q;
    logic [15:0] b_q;
    logic [15:0] alu_out;
    logic [15:0] mdr;

    opcode_t     op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    logic [15:0] alu_b;
    logic [2:0]  alu_fn;
    logic [15:0] alu_result;

    assign op     = opcode_t'(ir[OP_HI:OP_LO]);
    assign rd     = ir[RD_HI:RD_LO];
    assign rs1    = ir[RS1_HI:RS1_LO];
    assign rs2    = ir[RS2_HI:RS2_LO];
    assign imm    = sext6(ir[IMM_HI:IMM_LO]);
    assign alu_fn = alu_fn_for(op);

    always_comb begin
        alu_b = b_q;
        if (op == OP_LUI) begin
            alu_b = {ir[7:0], 8'h00};
        end else if (op inside {OP_ADDI, OP_LW, OP_SW}) begin
            alu_b = imm;
        end
    end

    alu16 u_alu (
        .a      (a_q),
        .b      (alu_b),
        .fn     (alu_fn),
        .result (alu_result)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_FETCH;
            pc_q    <= RESET_PC;
            ir      <= '0;
            a_q     <= '0;
            b_q     <= '0;
            alu_out <= '0;
            mdr     <= '0;
        end else begin
            case (state)
                S_FETCH: begin
                    if (memReady) begin
                        ir    <= memReadData;
                        pc_q  <= pc_q + 16'd1;
                        state <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    a_q   <= data1;
                    b_q   <= data2;
                    state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    alu_out <= alu_result;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI, OP_LUI:
                            state <= S_WRITEBACK;
                        OP_LW, OP_SW:
                            state <= S_MEM;
                        OP_BEQ: begin
                            if (a_q == b_q) begin
                                pc_q <= pc_q + imm;
                            end
                            state <= S_FETCH;
                        end
                        OP_JMP: begin
                            pc_q  <= {pc_q[15:12], ir[11:0]};
                            state <= S_FETCH;
                        end
                        default: state <= S_HALT;
                    endcase
                end
                S_MEM: begin
                    if (memReady) begin
                        if (op == OP_LW) begin
                            mdr   <= memReadData;
                            state <= S_WRITEBACK;
                        end else begin
                            state <= S_FETCH;
                        end
                    end
                end
                S_WRITEBACK: state <= S_FETCH;
                S_HALT:      state <= S_HALT;
                default:     state <= S_HALT;
            endcase
        end
    end

    // Outputs decode straight from state so the first fetch appears in the first
    // cycle after reset and a mid-access reset drops the request before its edge.
    always_comb begin
        memAddr        = '0;
        memWriteData   = '0;
        memRead        = 1'b0;
        memWrite       = 1'b0;
        regSource1     = '0;
        regSource2     = '0;
        regDestination = '0;
        writeData      = '0;
        writeEnable    = 1'b0;
        halted         = 1'b0;
        pc             = reset ? RESET_PC : pc_q;
        if (!reset) begin
            regSource1     = rs1;
            regSource2     = (op == OP_SW || op == OP_BEQ) ? rd : rs2;
            regDestination = rd;
            writeData      = (op == OP_LW) ? mdr : alu_out;
            case (state)
                S_FETCH: begin
                    memRead = 1'b1;
                    memAddr = pc_q;
                end
                S_MEM: begin
                    memAddr = alu_out;
                    if (op == OP_SW) begin
                        memWrite     = 1'b1;
                        memWriteData = b_q;
                    end else begin
                        memRead = 1'b1;
                    end
                end
                S_WRITEBACK: writeEnable = 1'b1;
                S_HALT:      halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: memory and register file are modelled
// here; expected values are hand-computed constants.
module tb_multicycle_control;

    logic        clock = 1'b0;
    logic        reset;
    logic [15:0] memAddr;
    logic [15:0] memWriteData;
    logic        memRead;
    logic        memWrite;
    logic        memReady;
    logic [15:0] memReadData;
    logic [2:0]  regSource1;
    logic [2:0]  regSource2;
    logic [2:0]  regDestination;
    logic [15:0] writeData;
    logic        writeEnable;
    logic [15:0] data1;
    logic [15:0] data2;
    logic        halted;
    logic [15:0] pc;

    logic        ready;
    logic [15:0] mem [0:65535];
    logic [15:0] regs [0:7];
    logic [7:0]  poke_mask = '0;
    logic [15:0] poke_val [0:7];
    int unsigned we_count = 0;
    int unsigned store_count = 0;
    logic [15:0] store_addr = '0;
    logic [15:0] store_data = '0;
    int unsigned we_snap;
    int unsigned st_snap;
    int          total = 0;
    int          bad = 0;

    always #5 clock = ~clock;

    multicycle_control #(.RESET_PC(16'h0000)) dut (
        .clock          (clock),
        .reset          (reset),
        .memAddr        (memAddr),
        .memWriteData   (memWriteData),
        .memRead        (memRead),
        .memWrite       (memWrite),
        .memReady       (memReady),
        .memReadData    (memReadData),
        .regSource1     (regSource1),
        .regSource2     (regSource2),
        .regDestination (regDestination),
        .writeData      (writeData),
        .writeEnable    (writeEnable),
        .data1          (data1),
        .data2          (data2),
        .halted         (halted),
        .pc             (pc)
    );

    assign memReady    = ready;
    assign memReadData = mem[memAddr];
    assign data1       = regs[regSource1];
    assign data2       = regs[regSource2];

    always @(posedge clock) begin
        if (writeEnable && regDestination != 3'd0) regs[regDestination] <= writeData;
        if (writeEnable) we_count <= we_count + 1;
        if (memWrite && memReady) begin
            store_count <= store_count + 1;
            store_addr  <= memAddr;
            store_data  <= memWriteData;
        end
        for (int i = 0; i < 8; i++) begin
            if (poke_mask[i]) regs[i] <= poke_val[i];
        end
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
        poke_mask = '0;
    endtask

    task automatic poke(input int unsigned r, input logic [15:0] v);
        poke_val[r]  = v;
        poke_mask[r] = 1'b1;
    endtask

    task automatic wait_fetch(input string tag, input logic [15:0] addr, input int unsigned budget);
        int unsigned n = 0;
        while (!(memRead === 1'b1 && memAddr === addr) && n < budget) begin
            next_cycle();
            n++;
        end
        check(tag, {15'b0, (memRead === 1'b1 && memAddr === addr)}, 16'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'hF000;
        mem[16'h0000] = 16'h6283;   // ADDI R1, R2, 3
        mem[16'h0001] = 16'h0650;   // ADD  R3, R1, R2
        mem[16'h0002] = 16'h1650;   // SUB  R3, R1, R2
        mem[16'h0003] = 16'h7842;   // LW   R4, 2(R1)
        mem[16'h0004] = 16'h8840;   // SW   R4, 0(R1)
        mem[16'h0005] = 16'h947E;   // BEQ  R1, R2, -2
        mem[16'h0006] = 16'hA005;   // JMP  0x005
        mem[16'h0012] = 16'hBEEF;
        for (int p = 0; p < 7; p++) mem[p * 4096 + 4095] = 16'hAFFF;
        mem[16'h7FFF] = 16'h6000;
        mem[16'h8000] = 16'hA123;
        mem[16'h8123] = 16'hF000;

        ready = 1'b1;
        reset = 1'b1;
        for (int unsigned i = 0; i < 8; i++) poke(i, 16'h0000);
        next_cycle();
        check("rst_read",  {15'b0, memRead}, 16'd0);
        check("rst_write", {15'b0, memWrite}, 16'd0);
        check("rst_we",    {15'b0, writeEnable}, 16'd0);
        check("rst_halt",  {15'b0, halted}, 16'd0);
        check("rst_pc",    pc, 16'h0000);
        check("rst_addr",  memAddr, 16'h0000);
        next_cycle();
        reset = 1'b0;
        #1;

        // ADDI R1, R2, 3
        check("addi_f_read", {15'b0, memRead}, 16'd1);
        check("addi_f_addr", memAddr, 16'h0000);
        next_cycle();
        check("addi_rs1", {13'b0, regSource1}, 16'd2);
        next_cycle();
        check("addi_e_we", {15'b0, writeEnable}, 16'd0);
        next_cycle();
        check("addi_we", {15'b0, writeEnable}, 16'd1);
        check("addi_rd", {13'b0, regDestination}, 16'd1);
        check("addi_wd", writeData, 16'h0003);
        check("addi_pc", pc, 16'h0001);

        // ADD R3 = 7FFF + 0001
        next_cycle();
        check("add_f_addr", memAddr, 16'h0001);
        poke(1, 16'h7FFF);
        poke(2, 16'h0001);
        repeat (3) next_cycle();
        check("add_we", {15'b0, writeEnable}, 16'd1);
        check("add_rd", {13'b0, regDestination}, 16'd3);
        check("add_wd", writeData, 16'h8000);

        // SUB R3 = 0000 - 0001
        next_cycle();
        check("sub_f_addr", memAddr, 16'h0002);
        poke(1, 16'h0000);
        poke(2, 16'h0001);
        repeat (3) next_cycle();
        check("sub_wd", writeData, 16'hFFFF);

        // LW R4, 2(R1) with two wait cycles in MEM
        next_cycle();
        check("lw_f_addr", memAddr, 16'h0003);
        poke(1, 16'h0010);
        next_cycle();
        check("lw_rs1", {13'b0, regSource1}, 16'd1);
        next_cycle();
        next_cycle();
        ready = 1'b0;
        check("lw_m1_read", {15'b0, memRead}, 16'd1);
        check("lw_m1_addr", memAddr, 16'h0012);
        next_cycle();
        check("lw_m2_addr", memAddr, 16'h0012);
        next_cycle();
        ready = 1'b1;
        check("lw_m3_addr", memAddr, 16'h0012);
        check("lw_m3_read", {15'b0, memRead}, 16'd1);
        next_cycle();
        check("lw_we", {15'b0, writeEnable}, 16'd1);
        check("lw_rd", {13'b0, regDestination}, 16'd4);
        check("lw_wd", writeData, 16'hBEEF);
        check("lw_wb_read", {15'b0, memRead}, 16'd0);

        // SW R4, 0(R1)
        next_cycle();
        check("sw_f_addr", memAddr, 16'h0004);
        we_snap = we_count;
        st_snap = store_count;
        next_cycle();
        check("sw_rs2", {13'b0, regSource2}, 16'd4);
        next_cycle();
        next_cycle();
        check("sw_write", {15'b0, memWrite}, 16'd1);
        check("sw_read",  {15'b0, memRead}, 16'd0);
        check("sw_addr",  memAddr, 16'h0010);
        check("sw_data",  memWriteData, 16'hBEEF);
        next_cycle();
        check("sw_drop",   {15'b0, memWrite}, 16'd0);
        check("sw_stores", 16'(store_count - st_snap), 16'd1);
        check("sw_st_addr", store_addr, 16'h0010);
        check("sw_st_data", store_data, 16'hBEEF);
        check("sw_no_we",  16'(we_count - we_snap), 16'd0);
        mem[16'h0004] = 16'hAFFF;

        // BEQ not taken (R1=0010, R2=0001)
        check("beq_f_addr", memAddr, 16'h0005);
        next_cycle();
        check("beq_rs2", {13'b0, regSource2}, 16'd2);
        next_cycle();
        next_cycle();
        check("beq_nt_addr", memAddr, 16'h0006);

        // JMP 0x005, then BEQ taken
        repeat (3) next_cycle();
        check("jmp_back_addr", memAddr, 16'h0005);
        poke(2, 16'h0010);
        repeat (3) next_cycle();
        check("beq_t_addr", memAddr, 16'h0004);

        wait_fetch("reach_8000", 16'h8000, 200);
        repeat (3) next_cycle();
        check("jmp_far_addr", memAddr, 16'h8123);
        repeat (3) next_cycle();
        check("halt_flag",  {15'b0, halted}, 16'd1);
        check("halt_pc",    pc, 16'h8124);
        for (int i = 0; i < 3; i++) begin
            ready = i[0];
            next_cycle();
            check("halt_idle", {14'b0, memRead, memWrite}, 16'd0);
        end

        // Reset in the middle of an LW memory access
        mem[16'h0000] = 16'h7A00;   // LW R5, 0(R0)
        poke(5, 16'h1234);
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        check("rl_pc",   pc, 16'h0000);
        check("rl_read", {15'b0, memRead}, 16'd1);
        check("rl_halt", {15'b0, halted}, 16'd0);
        repeat (3) next_cycle();
        ready = 1'b0;
        check("rl_m_read", {15'b0, memRead}, 16'd1);
        check("rl_m_addr", memAddr, 16'h0000);
        we_snap = we_count;
        reset = 1'b1;
        #1;
        check("rl_abort_read", {15'b0, memRead}, 16'd0);
        check("rl_abort_pc",   pc, 16'h0000);
        next_cycle();
        ready = 1'b1;
        reset = 1'b0;
        #1;
        check("rl_refetch", memAddr, 16'h0000);
        check("rl_refetch_read", {15'b0, memRead}, 16'd1);

        // Reset during WRITEBACK of the same LW
        repeat (4) next_cycle();
        check("rw_we", {15'b0, writeEnable}, 16'd1);
        check("rw_wd", writeData, 16'h7A00);
        reset = 1'b1;
        #1;
        check("rw_abort_we", {15'b0, writeEnable}, 16'd0);
        next_cycle();
        check("rw_r5", regs[5], 16'h1234);
        check("rw_no_we", 16'(we_count - we_snap), 16'd0);
        reset = 1'b0;
        #1;
        check("rw_pc", pc, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
